// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: ISA encodings, write-data select, and register-file sizing.
package lc2k_pkg;

  localparam int unsigned REG_ADDR_W  = 3;
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 8;
  localparam int unsigned RF_CNT_W    = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_NOR  = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_JALR = 3'd5,
    OP_HALT = 3'd6,
    OP_NOOP = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    WDS_MEM = 2'd0,
    WDS_ALU = 2'd1,
    WDS_PC1 = 2'd2
  } wdSel_t;

  // Instructions that produce a register destination and therefore issue here.
  function automatic logic writesReg(input opcode_t op);
    return op inside {OP_ADD, OP_NOR, OP_LW, OP_JALR};
  endfunction

endpackage

// File: rtl/lc2k_reg_file_if.sv
// Issue / writeback / dual-read bus between the pipeline and the LC2K register file.
interface lc2k_reg_file_if
  import lc2k_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W
) ();

  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_reg;
  logic                  iss_ready;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0]     wb_value;
  logic [REG_ADDR_W-1:0] rd_a_addr;
  logic [REG_ADDR_W-1:0] rd_b_addr;
  logic [DATA_W-1:0]     rd_a_data;
  logic [DATA_W-1:0]     rd_b_data;
  logic                  rd_a_busy;
  logic                  rd_b_busy;
  logic                  wb_err;

  modport master (
    output iss_valid, iss_reg, wb_valid, wb_reg, wb_value, rd_a_addr, rd_b_addr,
    input  iss_ready, rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, wb_err
  );

  modport slave (
    input  iss_valid, iss_reg, wb_valid, wb_reg, wb_value, rd_a_addr, rd_b_addr,
    output iss_ready, rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, wb_err
  );

endinterface

// File: rtl/lc2k_reg_file_pend_cnt.sv
// Saturating pending-write counter for one architectural register.
module lc2k_pend_cnt
  import lc2k_pkg::*;
#(
  parameter int unsigned CNT_W = RF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             zero
);

  assign sat  = (count == '1);
  assign zero = (count == '0);

  // Simultaneous inc/dec cancels; both ends clamp rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !sat) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lc2k_reg_file.sv
// LC2K register file with write-through bypass and per-register pending-write scoreboard.
module lc2k_reg_file
  import lc2k_pkg::*;
#(
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned CNT_W    = RF_CNT_W
) (
  input logic           clk,
  input logic           rst_n,
  lc2k_reg_file_if.slave bus
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [CNT_W-1:0]    cnt  [NUM_REGS];
  logic [NUM_REGS-1:0] incVec;
  logic [NUM_REGS-1:0] decVec;
  logic [NUM_REGS-1:0] satVec;
  logic [NUM_REGS-1:0] zeroVec;
  logic                issAccept;
  logic                wbLive;
  logic                issBlocked;
  logic                errQ;

  assign wbLive    = bus.wb_valid && (bus.wb_reg != '0);
  assign issAccept = bus.iss_valid && bus.iss_ready;

  // A writeback to the same register this cycle frees a slot, so it unblocks a full counter.
  assign issBlocked    = (bus.iss_reg != '0) && satVec[bus.iss_reg]
                         && !(bus.wb_valid && (bus.wb_reg == bus.iss_reg));
  assign bus.iss_ready = !issBlocked;

  // r0 is hardwired: never pending, never busy.
  assign cnt[0]     = '0;
  assign incVec[0]  = 1'b0;
  assign decVec[0]  = 1'b0;
  assign satVec[0]  = 1'b0;
  assign zeroVec[0] = 1'b1;

  for (genvar g = 1; g < NUM_REGS; g++) begin : gPend
    assign incVec[g] = issAccept && (bus.iss_reg == REG_ADDR_W'(g));
    assign decVec[g] = bus.wb_valid && (bus.wb_reg == REG_ADDR_W'(g));

    lc2k_pend_cnt #(
      .CNT_W(CNT_W)
    ) uCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (incVec[g]),
      .dec   (decVec[g]),
      .count (cnt[g]),
      .sat   (satVec[g]),
      .zero  (zeroVec[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wbLive) begin
      regs[bus.wb_reg] <= bus.wb_value;
    end
  end

  // Unmatched writeback: data is still committed, but the protocol error is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errQ <= 1'b0;
    end else if (wbLive && zeroVec[bus.wb_reg] && !incVec[bus.wb_reg]) begin
      errQ <= 1'b1;
    end
  end

  assign bus.wb_err = errQ;

  assign bus.rd_a_data = (bus.rd_a_addr == '0) ? '0 :
                         (bus.wb_valid && (bus.wb_reg == bus.rd_a_addr)) ? bus.wb_value :
                         regs[bus.rd_a_addr];
  assign bus.rd_b_data = (bus.rd_b_addr == '0) ? '0 :
                         (bus.wb_valid && (bus.wb_reg == bus.rd_b_addr)) ? bus.wb_value :
                         regs[bus.rd_b_addr];

  // The last outstanding write landing this cycle is already visible through the bypass.
  assign bus.rd_a_busy = !zeroVec[bus.rd_a_addr]
                         && !(bus.wb_valid && (bus.wb_reg == bus.rd_a_addr)
                              && (cnt[bus.rd_a_addr] == CNT_W'(1)));
  assign bus.rd_b_busy = !zeroVec[bus.rd_b_addr]
                         && !(bus.wb_valid && (bus.wb_reg == bus.rd_b_addr)
                              && (cnt[bus.rd_b_addr] == CNT_W'(1)));

endmodule

// File: tb/tb_lc2k_reg_file.sv
// Randomised and directed bench for lc2k_reg_file against a behavioural scoreboard model.
module tb_lc2k_reg_file;
  import lc2k_pkg::*;

  localparam int MAXP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc2k_reg_file_if #(.DATA_W(32)) bus ();

  lc2k_reg_file #(
    .NUM_REGS(8),
    .DATA_W  (32),
    .CNT_W   (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned vecCnt  = 0;
  int unsigned missCnt = 0;

  logic [31:0] mRegs [8];
  int          mPend [8];
  bit          mErr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      missCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    for (int r = 0; r < 8; r++) begin
      mRegs[r] = '0;
      mPend[r] = 0;
    end
    mErr = 1'b0;
  endfunction

  function automatic bit wbHits(input int r);
    return bus.wb_valid && (int'(bus.wb_reg) == r) && (r != 0);
  endfunction

  function automatic logic [31:0] expData(input int a);
    if (a == 0) return '0;
    if (wbHits(a)) return bus.wb_value;
    return mRegs[a];
  endfunction

  function automatic bit expBusy(input int a);
    if (a == 0 || mPend[a] == 0) return 1'b0;
    return !(wbHits(a) && mPend[a] == 1);
  endfunction

  function automatic bit expReady();
    int r = int'(bus.iss_reg);
    return !(r != 0 && mPend[r] == MAXP && !wbHits(r));
  endfunction

  function automatic void modelStep(input bit acc);
    int  ir  = int'(bus.iss_reg);
    int  wr  = int'(bus.wb_reg);
    bit  isI = acc && ir != 0;
    bit  isW = bus.wb_valid && wr != 0;
    if (isW) mRegs[wr] = bus.wb_value;
    if (!(isI && isW && ir == wr)) begin
      if (isI && mPend[ir] < MAXP) mPend[ir]++;
      if (isW) begin
        if (mPend[wr] == 0) mErr = 1'b1;
        else mPend[wr]--;
      end
    end
  endfunction

  task automatic drive(input bit iv, input int ir, input bit wv, input int wr,
                       input logic [31:0] wval, input int ra, input int rb);
    bus.iss_valid = iv;
    bus.iss_reg   = 3'(ir);
    bus.wb_valid  = wv;
    bus.wb_reg    = 3'(wr);
    bus.wb_value  = wval;
    bus.rd_a_addr = 3'(ra);
    bus.rd_b_addr = 3'(rb);
    #2;
  endtask

  task automatic checkAll(input string tag);
    chk({tag, "_rdA"},  bus.rd_a_data, expData(int'(bus.rd_a_addr)));
    chk({tag, "_rdB"},  bus.rd_b_data, expData(int'(bus.rd_b_addr)));
    chk({tag, "_bsyA"}, 32'(bus.rd_a_busy), 32'(expBusy(int'(bus.rd_a_addr))));
    chk({tag, "_bsyB"}, 32'(bus.rd_b_busy), 32'(expBusy(int'(bus.rd_b_addr))));
    chk({tag, "_rdy"},  32'(bus.iss_ready), 32'(expReady()));
    chk({tag, "_err"},  32'(bus.wb_err), 32'(mErr));
  endtask

  task automatic step();
    bit acc = bus.iss_valid && expReady();
    @(posedge clk);
    modelStep(acc);
    @(negedge clk);
  endtask

  task automatic applyVec(input string tag, input bit iv, input int ir, input bit wv,
                          input int wr, input logic [31:0] wval, input int ra, input int rb);
    drive(iv, ir, wv, wr, wval, ra, rb);
    checkAll(tag);
    step();
  endtask

  // Pulls reset low part-way through a cycle and checks the outputs clear without a clock edge.
  task automatic midCycleReset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cands[$];
    int wr;
    modelReset();
    drive(0, 0, 0, 0, '0, 0, 0);
    checkAll("rstHeld");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) applyVec("s019", 0, 0, 0, 0, '0, i, 7 - i);

    // issue r3, then see it busy, then bypassed writeback
    applyVec("s020iss", 1, 3, 0, 0, '0, 0, 0);
    drive(0, 0, 0, 0, '0, 3, 0);
    checkAll("s020pend");
    chk("s020_busy1", 32'(bus.rd_a_busy), 32'd1);
    step();
    drive(0, 0, 1, 3, 32'h0000_00FF, 3, 0);
    checkAll("s020wb");
    chk("s020_bypFF", bus.rd_a_data, 32'hFF);
    chk("s020_busy0", 32'(bus.rd_a_busy), 32'd0);
    step();
    drive(0, 0, 0, 0, '0, 3, 0);
    chk("s020_heldFF", bus.rd_a_data, 32'hFF);
    step();

    // saturate r5
    for (int i = 0; i < 3; i++) applyVec("s021iss", 1, 5, 0, 0, '0, 5, 0);
    drive(1, 5, 0, 0, '0, 5, 0);
    checkAll("s021full");
    chk("s021_rdy0", 32'(bus.iss_ready), 32'd0);
    step();
    drive(1, 5, 1, 5, 32'h55, 5, 0);
    checkAll("s021both");
    chk("s021_rdy1", 32'(bus.iss_ready), 32'd1);
    step();
    drive(1, 5, 0, 0, '0, 5, 0);
    chk("s021_stay3", 32'(bus.iss_ready), 32'd0);
    step();

    drive(0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0);
    checkAll("s022r0");
    chk("s022_r0zero", bus.rd_a_data, 32'd0);
    step();
    drive(0, 0, 0, 0, '0, 0, 0);
    chk("s022_err0", 32'(bus.wb_err), 32'd0);
    step();
    applyVec("s022wb2", 0, 0, 1, 2, 32'hA5A5_0001, 2, 0);
    drive(0, 0, 0, 0, '0, 2, 0);
    checkAll("s022after");
    chk("s022_r2", bus.rd_a_data, 32'hA5A5_0001);
    chk("s022_err1", 32'(bus.wb_err), 32'd1);
    step();
    applyVec("s022sticky", 0, 0, 0, 0, '0, 2, 5);

    applyVec("s024pre", 1, 7, 0, 0, '0, 0, 0);
    drive(1, 1, 1, 7, 32'h1234, 1, 7);
    checkAll("s024same");
    chk("s024_r7", bus.rd_b_data, 32'h1234);
    chk("s024_r7bsy", 32'(bus.rd_b_busy), 32'd0);
    step();
    drive(0, 0, 0, 0, '0, 1, 7);
    checkAll("s024next");
    chk("s024_r1bsy", 32'(bus.rd_a_busy), 32'd1);
    step();

    applyVec("s023i4", 1, 4, 0, 0, '0, 4, 6);
    applyVec("s023i6", 1, 6, 0, 0, '0, 4, 6);
    drive(0, 0, 0, 0, '0, 4, 6);
    checkAll("s023pre");
    midCycleReset("s023rst");
    applyVec("s015wb4", 0, 0, 1, 4, 32'h0BAD_CAFE, 4, 6);
    applyVec("s015err", 0, 0, 0, 0, '0, 4, 6);

    for (int blk = 0; blk < 8; blk++) begin
      for (int n = 0; n < 200; n++) begin
        cands.delete();
        for (int r = 1; r < 8; r++) if (mPend[r] > 0) cands.push_back(r);
        wr = int'($urandom_range(0, 7));
        if (cands.size() > 0 && $urandom_range(0, 3) != 0)
          wr = cands[$urandom_range(0, cands.size() - 1)];
        applyVec("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), wr, $urandom(),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
      drive(0, 0, 0, 0, '0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      midCycleReset("rndRst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule

// File: doc/lc2k_reg_file.md
LC2K_REG_FILE -- requirements
Module: lc2k_reg_file

Interface
REQ-001 The clock and reset SHALL be: one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-002 Parameters SHALL be:
- NUM_REGS, default 8: architectural register count.
- DATA_W, default 32: register width.
- CNT_W, default 2: width of the per-register pending-write counter.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: async active-low reset.
- iss_valid, in, 1: an instruction with a register destination issues.
- iss_reg, in, 3: destination register of the issuing instruction.
- iss_ready, out, 1: issue accepted this cycle.
- wb_valid, in, 1: writeback strobe from the write-data select stage.
- wb_reg, in, 3: writeback destination.
- wb_value, in, DATA_W: selected writeback value (memory, ALU or pc+1).
- rd_a_addr, in, 3: read port A address.
- rd_b_addr, in, 3: read port B address.
- rd_a_data, out, DATA_W: read port A data.
- rd_b_data, out, DATA_W: read port B data.
- rd_a_busy, out, 1: port A register has pending writes.
- rd_b_busy, out, 1: port B register has pending writes.
- wb_err, out, 1: sticky protocol-error flag.

Function
REQ-004 The block SHALL hold NUM_REGS registers of DATA_W bits. Register 0 SHALL always read 0, ignore writes, never count pending writes, and never report busy.
REQ-005 A write SHALL occur on a clock edge when wb_valid=1 and wb_reg!=0. The register SHALL take wb_value at that edge.
REQ-006 Reads SHALL be combinational. When wb_valid=1 and wb_reg equals a nonzero read address, that port SHALL return wb_value in the same cycle (write-through bypass).
REQ-007 Each nonzero register SHALL have a saturating CNT_W-bit pending counter:
- +1 on an accepted issue to that register.
- -1 on a writeback to that register.
- Unchanged when both happen to the same register in the same cycle.
REQ-008 rd_x_busy SHALL be 1 when the addressed register's counter is nonzero and no same-cycle writeback would bring it to zero. In other words, the bypass clears busy when the counter is 1 and a writeback to that register arrives.
REQ-009 iss_ready SHALL be 0 only when iss_reg is nonzero and its counter equals 2^CNT_W-1 with no same-cycle writeback to iss_reg. Otherwise iss_ready SHALL be 1.
REQ-010 An issue SHALL be accepted when iss_valid=1 and iss_ready=1. iss_valid with iss_reg=0 SHALL be accepted with no effect.
REQ-011 When a writeback arrives for a register whose counter is 0 (with no same-cycle issue to it), the data SHALL still be written. The counter SHALL stay at 0, and wb_err SHALL set and remain 1 until reset.
REQ-012 Issue and writeback to different registers in the same cycle SHALL update each counter independently.
REQ-013 Outputs SHALL have no X under any input combination with known inputs.

Reset
REQ-014 While rst_n=0, the block SHALL asynchronously force all registers, all counters and wb_err to 0. As a result, rd_x_data=0, rd_x_busy=0 and iss_ready=1.
REQ-015 An assertion of rst_n during pending writes SHALL discard all pending state. Writebacks after reset deassertion SHALL be treated per REQ-011.
REQ-016 Reset deassertion SHALL be synchronised externally; the first active edge after deassertion is a normal cycle.

Structure
REQ-017 The following SHALL live in the shared LC2K package, alongside the opcode and write-data-select encodings: the register-address width (3), DATA_W, NUM_REGS and CNT_W.
REQ-018 The per-register pending counter SHALL be a sub-module, lc2k_pend_cnt, with inputs inc, dec and outputs count, sat, zero. It SHALL be instantiated NUM_REGS-1 times.

Verification
REQ-019 Scenario: reset, then read all registers. Required: every rd_a/rd_b read = 0, busy = 0, iss_ready = 1, wb_err = 0.
REQ-020 Scenario: issue r3; next cycle rd_a_addr=3. Required: rd_a_busy = 1. Then wb r3 = 0x0000_00FF. Required: same cycle rd_a_data = 0xFF and rd_a_busy = 0; the following cycle still 0xFF.
REQ-021 Scenario: issue r5 three times (CNT_W=2). Required: iss_ready = 0 for a 4th issue to r5. Then wb r5 and issue r5 in the same cycle. Required: iss_ready = 1 and the counter stays at 3.
REQ-022 Scenario: wb r0 = 0xDEAD_BEEF. Required: r0 reads 0 and wb_err = 0. Then wb r2 with no prior issue. Required: r2 is written and wb_err = 1, sticky.
REQ-023 Scenario: issue r4 and r6, assert rst_n low mid-cycle. Required: immediately all busy = 0 and data = 0, with no wait for a clock edge.
REQ-024 Scenario: simultaneous issue r1, wb r7 = 0x1234 (r7 pending 1), and reads r1/r7. Required: rd r1 busy = 1 next cycle, rd r7 = 0x1234 with busy = 0.
